// File: rtl/rsp_s2_prep_ahbic_in_stage.sv
// AHB interconnect input stage: holds a master address phase until the shared slave port is granted.
// Optional RSP_S2_PREP_AHBIC_LOCK_EN forwards HMASTLOCKS and keeps the request up across a locked sequence.
module rsp_s2_prep_ahbic_in_stage (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        HSELS,
  input  logic [31:0] HADDRS,
  input  logic [1:0]  HTRANSS,
  input  logic        HWRITES,
  input  logic [2:0]  HSIZES,
  input  logic [2:0]  HBURSTS,
  input  logic [3:0]  HPROTS,
  input  logic        HMASTLOCKS,
  input  logic        HREADYS,
  output logic        HREADYOUTS,
  output logic        HRESPS,
  output logic        req_op,
  output logic        sel_op,
  output logic [31:0] addr_op,
  output logic [1:0]  trans_op,
  output logic        write_op,
  output logic [2:0]  size_op,
  output logic [2:0]  burst_op,
  output logic [3:0]  prot_op,
  output logic        mastlock_op,
  input  logic        active_op,
  input  logic        readyout_op,
  input  logic        resp_op
);

  typedef enum logic [1:0] {IDLE = 2'd0, PEND = 2'd1, DATA = 2'd2} state_t;

  state_t      state, state_nxt;
  logic        vap, accept, capture, pend;
  logic [31:0] hold_addr;
  logic [1:0]  hold_trans;
  logic        hold_write;
  logic [2:0]  hold_size;
  logic [2:0]  hold_burst;
  logic [3:0]  hold_prot;

  assign vap    = HSELS & HTRANSS[1] & HREADYS;
  assign pend   = (state == PEND);
  assign accept = active_op & readyout_op & (pend | vap);

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    capture    = 1'b0;
    HREADYOUTS = 1'b1;
    HRESPS     = 1'b0;
    case (state)
      PEND: begin
        HREADYOUTS = 1'b0;
        if (accept) state_nxt = DATA;
      end
      default: begin
        if (state == DATA) begin
          HREADYOUTS = readyout_op;
          HRESPS     = resp_op;
        end
        // A DATA phase stretched by the slave blocks any new address phase
        if (state != DATA || readyout_op) begin
          if (vap && accept) begin
            state_nxt = DATA;
          end else if (vap) begin
            state_nxt = PEND;
            capture   = 1'b1;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      hold_addr  <= '0;
      hold_trans <= '0;
      hold_write <= 1'b0;
      hold_size  <= '0;
      hold_burst <= '0;
      hold_prot  <= '0;
    end else if (capture) begin
      hold_addr  <= HADDRS;
      hold_trans <= HTRANSS;
      hold_write <= HWRITES;
      hold_size  <= HSIZES;
      hold_burst <= HBURSTS;
      hold_prot  <= HPROTS;
    end
  end

  assign sel_op   = pend | (HSELS & HREADYS);
  assign addr_op  = pend ? hold_addr  : HADDRS;
  assign trans_op = pend ? hold_trans : HTRANSS;
  assign write_op = pend ? hold_write : HWRITES;
  assign size_op  = pend ? hold_size  : HSIZES;
  assign burst_op = pend ? hold_burst : HBURSTS;
  assign prot_op  = pend ? hold_prot  : HPROTS;

`ifdef RSP_S2_PREP_AHBIC_LOCK_EN
  logic hold_lock, lock_last;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      hold_lock <= 1'b0;
      lock_last <= 1'b0;
    end else begin
      if (capture) hold_lock <= HMASTLOCKS;
      if (accept)  lock_last <= mastlock_op;
    end
  end

  assign mastlock_op = pend ? hold_lock : HMASTLOCKS;
  // Keep ownership of the shared slave between beats of a locked sequence
  assign req_op = pend | vap | ((state == IDLE) & lock_last & HMASTLOCKS);
`else
  logic unused_lock;
  assign unused_lock = HMASTLOCKS;
  assign mastlock_op = 1'b0;
  assign req_op      = pend | vap;
`endif

endmodule
